// File: rtl/fpga_cfg_pkg.sv
// Shared types and sizing helpers for the fabric configuration loader.
// Imported by cfg_piso and fpga_config_loader.
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        DONE
    } state_t;

    localparam int DEF_WORD_W    = 32;
    localparam int DEF_CHAIN_LEN = 4096;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/fpga_config_loader_piso.sv
// Word-wide parallel-in/serial-out register for the configuration loader.
// Load presents bit 0 externally; the register keeps the remaining bits.
module cfg_piso
    import fpga_cfg_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int IDX_W  = clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_bit,
    output logic [IDX_W-1:0]  o_idx
);

    logic [WORD_W-1:0] r_sreg;
    logic [IDX_W-1:0]  r_idx;

    // r_idx counts bits of the current word already issued to the chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_sreg <= i_data >> 1;
            r_idx  <= IDX_W'(1);
        end else if (i_shift) begin
            r_sreg <= r_sreg >> 1;
            r_idx  <= r_idx + IDX_W'(1);
        end
    end

    assign o_bit = r_sreg[0];
    assign o_idx = r_idx;

endmodule

// File: rtl/fpga_config_loader.sv
// Serial configuration chain loader: words in, cen/shift_in/cset out.
// Optional readback of the chain output is enabled by CFG_READBACK_EN.
module fpga_config_loader
    import fpga_cfg_pkg::*;
#(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int CHAIN_LEN   = DEF_CHAIN_LEN,
    parameter int CSET_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              cfg_cen,
    output logic              cfg_shift,
    output logic              cfg_set,
    output logic              busy,
    output logic              done,
`ifdef CFG_READBACK_EN
    input  logic              chain_in,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
`endif
    output logic [CNT_W-1:0]  bits_sent
);

    localparam int IDX_W = clog2(WORD_W + 1);
    localparam int SET_W = clog2(CSET_CYCLES + 1);

    state_t           r_state;
    logic             r_ready;
    logic             r_cen;
    logic             r_shift;
    logic             r_set;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_bits;
    logic [SET_W-1:0] r_set_cnt;

    logic             w_bit;
    logic [IDX_W-1:0] w_idx;
    logic             w_last;
    logic             w_word_end;
    logic             w_load;
    logic             w_issue;
    logic [CNT_W-1:0] w_bits_inc;

    assign w_last     = (r_bits == CNT_W'(CHAIN_LEN));
    assign w_word_end = (w_idx == IDX_W'(WORD_W));
    assign w_load     = (r_state == LOAD) && cfg_valid && !abort;
    assign w_issue    = (r_state == SHIFT) && !abort && !w_last && !w_word_end;
    assign w_bits_inc = w_last ? r_bits : r_bits + CNT_W'(1);

    cfg_piso #(
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W)
    ) u_piso (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_shift (w_issue),
        .i_data  (cfg_data),
        .o_bit   (w_bit),
        .o_idx   (w_idx)
    );

    // SHIFT cycles coincide with cfg_cen=1; outputs are set on the entry edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ready   <= 1'b0;
            r_cen     <= 1'b0;
            r_shift   <= 1'b0;
            r_set     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bits    <= '0;
            r_set_cnt <= '0;
        end else if (abort) begin
            r_state   <= IDLE;
            r_ready   <= 1'b0;
            r_cen     <= 1'b0;
            r_shift   <= 1'b0;
            r_set     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_set_cnt <= '0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_bits  <= '0;
                    end
                end
                LOAD: begin
                    if (cfg_valid) begin
                        r_state <= SHIFT;
                        r_ready <= 1'b0;
                        r_cen   <= 1'b1;
                        r_shift <= cfg_data[0];
                        r_bits  <= w_bits_inc;
                    end
                end
                SHIFT: begin
                    if (w_last) begin
                        r_state   <= LATCH;
                        r_cen     <= 1'b0;
                        r_shift   <= 1'b0;
                        r_set     <= 1'b1;
                        r_set_cnt <= '0;
                    end else if (w_word_end) begin
                        r_state <= LOAD;
                        r_cen   <= 1'b0;
                        r_shift <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_shift <= w_bit;
                        r_bits  <= w_bits_inc;
                    end
                end
                LATCH: begin
                    if (r_set_cnt == SET_W'(CSET_CYCLES - 1)) begin
                        r_state <= DONE;
                        r_set   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_set_cnt <= r_set_cnt + SET_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cfg_ready = r_ready;
    assign cfg_cen   = r_cen;
    assign cfg_shift = r_shift;
    assign cfg_set   = r_set;
    assign busy      = r_busy;
    assign done      = r_done;
    assign bits_sent = r_bits;

`ifdef CFG_READBACK_EN
    logic [WORD_W-1:0] r_rb_acc;
    logic [WORD_W-1:0] r_rb_data;
    logic              r_rb_valid;
    logic [WORD_W-1:0] w_rb_word;

    // Bit position tracks the bit currently on the chain: w_idx - 1
    assign w_rb_word = r_rb_acc
                     | (WORD_W'(chain_in) << (w_idx - IDX_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rb_acc   <= '0;
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            if (abort) begin
                r_rb_acc <= '0;
            end else if (r_cen) begin
                if (w_word_end || w_last) begin
                    r_rb_data  <= w_rb_word;
                    r_rb_valid <= 1'b1;
                    r_rb_acc   <= '0;
                end else begin
                    r_rb_acc <= w_rb_word;
                end
            end
        end
    end

    assign rb_data  = r_rb_data;
    assign rb_valid = r_rb_valid;
`endif

endmodule

// File: tb/tb_fpga_config_loader.sv
// Randomised bench for fpga_config_loader against a stream/timing model.
// Define CFG_READBACK_EN to also exercise the chain readback path.
module tb_fpga_config_loader;

    localparam int W  = 32;
    localparam int L  = 40;
    localparam int CS = 1;
    localparam int CW = 16;
    localparam int NW = (L + W - 1) / W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [W-1:0]  cfg_data = '0;
    logic          cfg_ready;
    logic          cfg_cen;
    logic          cfg_shift;
    logic          cfg_set;
    logic          busy;
    logic          done;
    logic [CW-1:0] bits_sent;

`ifdef CFG_READBACK_EN
    logic          chain_in;
    logic [W-1:0]  rb_data;
    logic          rb_valid;
    logic [L-1:0]  chain = '0;
    assign chain_in = chain[L-1];
    always @(posedge clk) if (cfg_cen) chain <= {chain[L-2:0], cfg_shift};
`endif

    fpga_config_loader #(
        .WORD_W      (W),
        .CHAIN_LEN   (L),
        .CSET_CYCLES (CS),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_data  (cfg_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_cen   (cfg_cen),
        .cfg_shift (cfg_shift),
        .cfg_set   (cfg_set),
        .busy      (busy),
        .done      (done),
`ifdef CFG_READBACK_EN
        .chain_in  (chain_in),
        .rb_data   (rb_data),
        .rb_valid  (rb_valid),
`endif
        .bits_sent (bits_sent)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int           cyc = 0;
    int           cen_q[$];
    bit           bit_q[$];
    int           hs_q[$];
    int           set_q[$];
    logic [W-1:0] rb_q[$];
    int           rdy_rise;
    bit           prev_rdy;
    int           bad_shift;
    logic         s_cen, s_busy, s_done, s_ready;
    logic [CW-1:0] s_bits;

    task automatic clear_logs();
        cen_q.delete(); bit_q.delete(); hs_q.delete();
        set_q.delete(); rb_q.delete();
        rdy_rise = 0; prev_rdy = 0; bad_shift = 0;
    endtask

    // One clock: sample on the falling edge, return just after the rise
    task automatic step();
        @(negedge clk);
        cyc++;
        s_cen = cfg_cen; s_busy = busy; s_done = done;
        s_ready = cfg_ready; s_bits = bits_sent;
        if (cfg_cen) begin
            cen_q.push_back(cyc);
            bit_q.push_back(cfg_shift);
        end
        if (!cfg_cen && cfg_shift) bad_shift++;
        if (cfg_ready && cfg_valid) hs_q.push_back(cyc);
        if (cfg_ready && !prev_rdy) rdy_rise++;
        prev_rdy = cfg_ready;
        if (cfg_set) set_q.push_back(cyc);
`ifdef CFG_READBACK_EN
        if (rb_valid) rb_q.push_back(rb_data);
`endif
        @(posedge clk);
        #1;
    endtask

    // Model: chain bit j is word j/W bit j%W, shown the cycle after
    // that word's handshake plus j%W; cset follows the last bit.
    task automatic verify(input logic [W-1:0] w0, input logic [W-1:0] w1);
        logic [W-1:0] words [NW];
        logic [63:0]  got, exp;
        int           bad, last_cen, first_set;
        words[0] = w0; words[1] = w1;
        got = '0; exp = '0; bad = 0;
        for (int j = 0; j < L; j++) begin
            exp[j] = words[j / W][j % W];
            if (j < bit_q.size()) got[j] = bit_q[j];
        end
        for (int j = 0; j < cen_q.size(); j++) begin
            if (j / W >= hs_q.size()) bad++;
            else if (cen_q[j] != hs_q[j / W] + 1 + j % W) bad++;
        end
        last_cen  = (cen_q.size() > 0) ? cen_q[cen_q.size() - 1] : -10;
        first_set = (set_q.size() > 0) ? set_q[0] : -20;
        check("cen_count", cen_q.size(), L);
        check("stream", got, exp);
        check("handshakes", hs_q.size(), NW);
        check("ready_pulses", rdy_rise, NW);
        check("bit_timing", bad, 0);
        check("set_len", set_q.size(), CS);
        check("set_pos", first_set, last_cen + 1);
        check("shift_gated", bad_shift, 0);
        check("done", s_done, 1);
        check("busy", s_busy, 0);
        check("bits_sent", s_bits, L);
    endtask

    task automatic run_load(input logic [W-1:0] w0, input logic [W-1:0] w1,
                            input int gap, input bit poke);
        logic [W-1:0] words [NW];
        int wi, hold, t;
        bit fin;
        words[0] = w0; words[1] = w1;
        wi = 0; hold = 0; t = 0; fin = 0;
        clear_logs();
        start = 1; cfg_valid = 0; step(); start = 0;
        while (!fin && t < 500) begin
            cfg_valid = (wi < NW && !(wi == 1 && hold < gap))
                      || (poke && wi == NW);
            cfg_data  = (wi < NW) ? words[wi] : W'($urandom);
            start     = poke && (t == 15);
            step();
            if (s_ready && cfg_valid) wi++;
            else if (s_ready && wi == 1) hold++;
            if (s_done) fin = 1;
            t++;
        end
        start = 0;
        check("done_timeout", fin, 1);
        cfg_valid = poke;
        repeat (4) step();
        cfg_valid = 0;
        verify(w0, w1);
    endtask

    task automatic run_abort(input int at);
        int t, n;
        clear_logs();
        start = 1; step(); start = 0;
        t = 0;
        while (cen_q.size() < at && t < 200) begin
            cfg_valid = 1; cfg_data = W'($urandom);
            step(); t++;
        end
        check("abort_reach", cen_q.size(), at);
        abort = 1; step(); abort = 0; cfg_valid = 0;
        step();
        check("abort_cen", s_cen, 0);
        check("abort_busy", s_busy, 0);
        check("abort_ready", s_ready, 0);
        n = cen_q.size();
        repeat (10) step();
        check("abort_no_set", set_q.size(), 0);
        check("abort_frozen", cen_q.size(), n);
    endtask

    task automatic run_reset_mid();
        int t;
        clear_logs();
        start = 1; step(); start = 0;
        t = 0;
        while (cen_q.size() < 10 && t < 200) begin
            cfg_valid = 1; cfg_data = W'($urandom);
            step(); t++;
        end
        #2 rst_n = 0;
        #1 check("rst_async_outs",
                 {cfg_ready, cfg_cen, cfg_shift, cfg_set, busy, done, bits_sent},
                 '0);
        repeat (2) step();
        #6 rst_n = 1;
        clear_logs();
        repeat (3) step();
        check("rst_idle_busy", s_busy, 0);
        check("rst_idle_hs", hs_q.size(), 0);
        cfg_valid = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs",
              {cfg_ready, cfg_cen, cfg_shift, cfg_set, busy, done, bits_sent},
              '0);
        rst_n = 1;
        step();
        check("idle_ready", s_ready, 0);

        run_load(32'hA5A5_0F0F, 32'h0000_00C3, 0, 0);
        run_load(32'hA5A5_0F0F, 32'h0000_00C3, 10, 0);
`ifdef CFG_READBACK_EN
        check("rb_count", rb_q.size(), 2);
        if (rb_q.size() == 2) begin
            check("rb_word0", rb_q[0], 32'hA5A5_0F0F);
            check("rb_word1", rb_q[1], 32'h0000_00C3);
        end
`endif
        run_load(W'($urandom), W'($urandom), $urandom_range(0, 12), 1);
        run_abort(20);
        run_load(W'($urandom), W'($urandom), $urandom_range(0, 12), 0);
        run_reset_mid();
        run_load(W'($urandom), W'($urandom), $urandom_range(0, 12), 0);
        repeat (5) begin
            run_load(W'($urandom), W'($urandom), $urandom_range(0, 12),
                     1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
